fb_pixel_sink: RTL and testbench
================================

# fb_pixel_sink

Receiving end of the pixel-plot stream that game controllers drive (x, y, colour, plot). Buffers plot requests in a small FIFO, clips them to the 160x120 screen, converts them to linear framebuffer addresses and writes them into a single-port framebuffer memory. It also serves colour read-back queries, which game logic uses for collision checks. Sits between the game `control` logic and the framebuffer RAM that the VGA scan-out reads.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, at least 2.
- `WIDTH`, default 160: screen width in pixels.
- `HEIGHT`, default 120: screen height in pixels.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `resetn`  in  1  reset; asynchronous, active-low.
- `in_x`  in  8  plot column.
- `in_y`  in  8  plot row.
- `in_colour`  in  3  plot colour, RGB.
- `in_plot`  in  1  plot request.
- `in_ready`  out  1  sink can accept a plot this cycle.
- `mem_addr`  out  15  framebuffer address.
- `mem_data`  out  3  write colour.
- `mem_wren`  out  1  write strobe.
- `mem_rden`  out  1  read strobe.
- `mem_ready`  in  1  memory accepts a strobe this cycle.
- `mem_rdata`  in  3  read data, valid 1 cycle after an accepted `mem_rden`.
- `rd_req`  in  1  read-back request, single-cycle pulse.
- `rd_x`  in  8  read-back column, sampled with `rd_req`.
- `rd_y`  in  8  read-back row, sampled with `rd_req`.
- `rd_busy`  out  1  read-back in progress.
- `rd_valid`  out  1  `rd_colour` valid; 1-cycle pulse.
- `rd_colour`  out  3  read-back result.
- `clip_count`  out  8  number of out-of-range plots discarded; saturates at 255.

## Operation
- Accept: a plot is taken on a `clk` edge where `in_plot && in_ready`.
- `in_ready` = !full && !rd_busy. When the FIFO is full, the sink is not ready even if a pop occurs in the same cycle.
- Clip: an accepted plot with `in_x >= WIDTH` or `in_y >= HEIGHT` is discarded, never enters the FIFO, and increments `clip_count` (saturating at 255).
- Address: `y*160 + x`, computed as (y<<7)+(y<<5)+x in 15 bits. Maximum value is 19199. The address is computed at push time and stored with the colour.
- Write stage: when the FIFO is non-empty, the FSM is in IDLE and `mem_ready` is high, the sink pops one entry and drives registered `mem_wren`=1 with `mem_addr`/`mem_data` for exactly one cycle. Throughput is 1 write per cycle.
- If `mem_ready` is low, pops stall and FIFO contents are held.
- FSM states:
  - IDLE: services writes. An `rd_req` here latches rd_x/rd_y and sets `rd_busy` on the next edge, going to DRAIN.
  - DRAIN: writes continue; inputs are blocked. Go to ISSUE when the FIFO is empty and no write is in flight.
  - ISSUE: `mem_rden`=1 with the read address; stays in ISSUE until `mem_ready`, then goes to WAIT.
  - WAIT: one cycle; captures `mem_rdata`, then goes to DONE.
  - DONE: `rd_valid`=1, `rd_busy`=0, back to IDLE.
- Out-of-range read: after DRAIN, skip ISSUE and WAIT and go straight to DONE with `rd_colour`=0. No memory access occurs.
- `rd_req` while `rd_busy` is ignored.
- A read always returns the colour after every plot accepted before `rd_req`.
- Reset mid-operation: the FIFO is emptied, a pending read is aborted with no `rd_valid`, and the FSM returns to IDLE.

## Timing
- Reset values: `in_ready`=1 (no plot is accepted while `resetn`=0), `mem_addr`=0, `mem_data`=0, `mem_wren`=0, `mem_rden`=0, `rd_busy`=0, `rd_valid`=0, `rd_colour`=0, `clip_count`=0.
- Write latency: a plot accepted at edge k into an empty FIFO, with `mem_ready` high, asserts `mem_wren` in the cycle following edge k+1.
- Read latency, with the FIFO empty and `mem_ready` high: `rd_req` at edge k → DRAIN k+1 → ISSUE k+2 → WAIT k+3 → `rd_valid` high after edge k+4.
- Simultaneous push and pop while not full: both take effect and the count is unchanged.
- Simultaneous `rd_req` and an accepted plot in IDLE: the plot is taken first and is included in the drain.
- All outputs are registered except `in_ready`.

## Configuration
- `FB_PIXEL_SINK_DEDUP_EN` defined: an in-range accepted plot identical (x, y, colour) to the last pushed plot is handshaken but not pushed.
  - The last-pushed register is cleared by reset only; reads do not clear it.
  - Clipped plots do not update it.
- Undefined: every in-range plot is pushed and written.

## Test plan
- Reset, then plot (157,110,3'b010) with `mem_ready`=1 → one `mem_wren` pulse, `mem_addr`=17757, `mem_data`=010, 2 edges after acceptance.
- Hold `mem_ready`=0 and stream 9 plots → `in_ready` falls after 8 accepted. Release `mem_ready` → 8 consecutive writes in order, no loss.
- Plots at (160,0), (0,120) and (255,255) → no writes, `clip_count`=3. Then 300 more out-of-range plots → `clip_count`=255.
- Write (5,5,3'b100) then `rd_req` (5,5) in the next cycle with the model RAM → `rd_colour`=100, `rd_valid` a single pulse. Read (200,5) → `rd_colour`=0, no `mem_rden`.
- `resetn` low while in DRAIN with 4 entries queued → no further `mem_wren`, no `rd_valid`, all outputs at reset values.
- With `FB_PIXEL_SINK_DEDUP_EN`: plot (1,110,3'b100) four times → exactly 1 write. Without the macro → 4 writes.

Source files
------------

// File: rtl/fb_pixel_sink_if.sv
// Plot stream from game control logic into the framebuffer pixel sink.
// Carries one (x, y, colour) plot per in_plot/in_ready handshake.
interface fb_pixel_sink_if;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic [2:0] in_colour;
  logic       in_plot;
  logic       in_ready;

  modport master (
    output in_x, in_y, in_colour, in_plot,
    input  in_ready
  );

  modport slave (
    input  in_x, in_y, in_colour, in_plot,
    output in_ready
  );
endinterface

// File: rtl/fb_pixel_sink.sv
// Pixel-plot sink: clip, FIFO, framebuffer writes and colour read-back.
// Optional FB_PIXEL_SINK_DEDUP_EN drops repeats of the last pushed plot.
module fb_pixel_sink #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clk,
  input  logic        resetn,
  fb_pixel_sink_if.slave plot,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_wren,
  output logic        mem_rden,
  input  logic        mem_ready,
  input  logic [2:0]  mem_rdata,
  input  logic        rd_req,
  input  logic [7:0]  rd_x,
  input  logic [7:0]  rd_y,
  output logic        rd_busy,
  output logic        rd_valid,
  output logic [2:0]  rd_colour,
  output logic [7:0]  clip_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  function automatic logic [14:0] lin(
    input logic [7:0] x,
    input logic [7:0] y
  );
    lin = {y, 7'b0}
        + {2'b0, y, 5'b0}
        + {7'b0, x};
  endfunction

  state_t state;

  logic [17:0]   fifo_mem [DEPTH];
  logic [17:0]   fifo_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [7:0] rx_q;
  logic [7:0] ry_q;

  logic full;
  logic empty;
  logic accept;
  logic in_range;
  logic dup;
  logic push;
  logic pop;
  logic rd_oor;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign fifo_q = fifo_mem[rd_ptr];

  assign plot.in_ready = !full && !rd_busy;

  assign accept   = plot.in_plot && plot.in_ready;
  assign in_range = ({1'b0, plot.in_x} < 9'(WIDTH))
                 && ({1'b0, plot.in_y} < 9'(HEIGHT));
  assign push     = accept && in_range && !dup;

  assign pop = !empty && mem_ready
            && (state == S_IDLE || state == S_DRAIN);

  assign rd_oor = ({1'b0, rx_q} >= 9'(WIDTH))
               || ({1'b0, ry_q} >= 9'(HEIGHT));

`ifdef FB_PIXEL_SINK_DEDUP_EN
  logic        last_vld;
  logic [18:0] last_q;

  assign dup = last_vld
            && last_q == {plot.in_x, plot.in_y, plot.in_colour};

  // Reads never clear this; only a fresh push replaces it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_vld <= 1'b0;
      last_q   <= '0;
    end else if (push) begin
      last_vld <= 1'b1;
      last_q   <= {plot.in_x, plot.in_y, plot.in_colour};
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <=
        {lin(plot.in_x, plot.in_y), plot.in_colour};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clip_count <= '0;
    end else if (accept && !in_range
                 && clip_count != 8'hff) begin
      clip_count <= clip_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
      rd_busy   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_colour <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
    end else begin
      mem_wren <= 1'b0;
      rd_valid <= 1'b0;
      if (pop) begin
        mem_wren <= 1'b1;
        mem_addr <= fifo_q[17:3];
        mem_data <= fifo_q[2:0];
      end
      unique case (state)
        S_IDLE: begin
          if (rd_req) begin
            rx_q    <= rd_x;
            ry_q    <= rd_y;
            rd_busy <= 1'b1;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Empty FIFO means no pop, so mem_addr is free here.
          if (empty && !mem_wren) begin
            if (rd_oor) begin
              rd_colour <= '0;
              state     <= S_DONE;
            end else begin
              mem_rden <= 1'b1;
              mem_addr <= lin(rx_q, ry_q);
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            mem_rden <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          rd_colour <= mem_rdata;
          state     <= S_DONE;
        end
        S_DONE: begin
          rd_valid <= 1'b1;
          rd_busy  <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Directed bench for fb_pixel_sink with a write scoreboard and model RAM.
// Expected writes are queued at acceptance and popped on each mem_wren.
module tb_fb_pixel_sink;

  logic        clk;
  logic        resetn;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_wren;
  logic        mem_rden;
  logic        mem_ready;
  logic [2:0]  mem_rdata;
  logic        rd_req;
  logic [7:0]  rd_x;
  logic [7:0]  rd_y;
  logic        rd_busy;
  logic        rd_valid;
  logic [2:0]  rd_colour;
  logic [7:0]  clip_count;

  fb_pixel_sink_if pi();

  fb_pixel_sink dut (
    .clk        (clk),
    .resetn     (resetn),
    .plot       (pi),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_rden   (mem_rden),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .rd_req     (rd_req),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_busy    (rd_busy),
    .rd_valid   (rd_valid),
    .rd_colour  (rd_colour),
    .clip_count (clip_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int rden_count = 0;
  int rdv_count  = 0;

  logic [17:0] sb [$];
  logic [2:0]  ram [0:32767];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] addr_of(
    input int x, input int y);
    addr_of = 15'(y * 160 + x);
  endfunction

  always @(posedge clk) begin
    if (mem_wren)
      ram[mem_addr] <= mem_data;
    if (mem_rden && mem_ready)
      mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (resetn && mem_wren) begin
      wr_count++;
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'h7fff);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[17:3]));
        check("wr_data", 32'(mem_data), 32'(e[2:0]));
      end
    end
    if (resetn && mem_rden && mem_ready)
      rden_count++;
    if (resetn && rd_valid)
      rdv_count++;
  end

  task automatic send(input int x, input int y,
                      input logic [2:0] c,
                      input bit exp_push);
    bit ok = 0;
    pi.in_x = 8'(x);
    pi.in_y = 8'(y);
    pi.in_colour = c;
    pi.in_plot = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (pi.in_ready) begin
        ok = 1;
        if (exp_push)
          sb.push_back({addr_of(x, y), c});
        @(posedge clk);
        #1;
      end
    end
    pi.in_plot = 1'b0;
    check("plot_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_rd_valid(output bit seen);
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (rd_valid) seen = 1;
    end
  endtask

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_in_ready"}, 32'(pi.in_ready), 1);
    check({pfx, "_mem_addr"}, 32'(mem_addr), 0);
    check({pfx, "_mem_data"}, 32'(mem_data), 0);
    check({pfx, "_mem_wren"}, 32'(mem_wren), 0);
    check({pfx, "_mem_rden"}, 32'(mem_rden), 0);
    check({pfx, "_rd_busy"}, 32'(rd_busy), 0);
    check({pfx, "_rd_valid"}, 32'(rd_valid), 0);
    check({pfx, "_rd_colour"}, 32'(rd_colour), 0);
    check({pfx, "_clip_count"}, 32'(clip_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int w0, r0, v0;
    resetn = 1'b0;
    mem_ready = 1'b1;
    rd_req = 1'b0;
    rd_x = '0;
    rd_y = '0;
    pi.in_x = '0;
    pi.in_y = '0;
    pi.in_colour = '0;
    pi.in_plot = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // single plot: write latency and address
    pi.in_x = 8'd157;
    pi.in_y = 8'd110;
    pi.in_colour = 3'b010;
    pi.in_plot = 1'b1;
    sb.push_back({addr_of(157, 110), 3'b010});
    @(posedge clk); #1;
    pi.in_plot = 1'b0;
    @(negedge clk);
    check("lat_wren_early", 32'(mem_wren), 0);
    @(negedge clk);
    check("lat_wren", 32'(mem_wren), 1);
    check("lat_addr", 32'(mem_addr), 17757);
    check("lat_data", 32'(mem_data), 3'b010);
    @(negedge clk);
    check("lat_single_pulse", 32'(mem_wren), 0);
    @(posedge clk); #1;

    // backpressure: fill FIFO with memory stalled
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(10 + i, 20 + i, 3'(i), 1);
    pi.in_x = 8'd50;
    pi.in_y = 8'd50;
    pi.in_colour = 3'd7;
    pi.in_plot = 1'b1;
    @(negedge clk);
    check("full_in_ready", 32'(pi.in_ready), 0);
    check("stall_no_wren", 32'(mem_wren), 0);
    pi.in_plot = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (mem_wren) seen = 1;
    end
    check("drain_start", 32'(seen), 1);
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      check("drain_back_to_back", 32'(mem_wren), 1);
    end
    @(negedge clk);
    check("drain_end", 32'(mem_wren), 0);
    @(posedge clk); #1;

    // clipping
    w0 = wr_count;
    send(160, 0, 3'd1, 0);
    send(0, 120, 3'd2, 0);
    send(255, 255, 3'd3, 0);
    repeat (4) @(negedge clk);
    check("clip_no_write", wr_count, w0);
    check("clip_count_3", 32'(clip_count), 3);
    @(posedge clk); #1;
    pi.in_x = 8'd200;
    pi.in_y = 8'd0;
    pi.in_plot = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    pi.in_plot = 1'b0;
    @(negedge clk);
    check("clip_saturate", 32'(clip_count), 255);
    check("clip_sat_no_write", wr_count, w0);
    @(posedge clk); #1;

    // read-back right behind a write
    pi.in_x = 8'd5;
    pi.in_y = 8'd5;
    pi.in_colour = 3'b100;
    pi.in_plot = 1'b1;
    sb.push_back({addr_of(5, 5), 3'b100});
    @(posedge clk); #1;
    pi.in_plot = 1'b0;
    rd_req = 1'b1;
    rd_x = 8'd5;
    rd_y = 8'd5;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check("rd_busy_blocks", 32'(pi.in_ready), 0);
    wait_rd_valid(seen);
    check("rd_seen", 32'(seen), 1);
    check("rd_colour", 32'(rd_colour), 3'b100);
    check("rd_busy_clear", 32'(rd_busy), 0);
    @(negedge clk);
    check("rd_valid_pulse", 32'(rd_valid), 0);
    @(posedge clk); #1;

    // read latency with empty FIFO
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (4) @(negedge clk);
    check("rd_lat_early", 32'(rd_valid), 0);
    @(negedge clk);
    check("rd_lat_valid", 32'(rd_valid), 1);
    check("rd_lat_colour", 32'(rd_colour), 3'b100);
    @(posedge clk); #1;

    // out-of-range read
    r0 = rden_count;
    rd_req = 1'b1;
    rd_x = 8'd200;
    rd_y = 8'd5;
    @(posedge clk); #1;
    rd_req = 1'b0;
    wait_rd_valid(seen);
    check("oor_seen", 32'(seen), 1);
    check("oor_colour", 32'(rd_colour), 0);
    check("oor_no_rden", rden_count, r0);
    @(posedge clk); #1;

    // reset while draining
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(30 + i, 40, 3'd6, 0);
    rd_req = 1'b1;
    rd_x = 8'd3;
    rd_y = 8'd3;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check("drain_busy", 32'(rd_busy), 1);
    w0 = wr_count;
    v0 = rdv_count;
    r0 = rden_count;
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outs("midrst");
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_write", wr_count, w0);
    check("midrst_no_valid", rdv_count, v0);
    check("midrst_no_rden", rden_count, r0);
    check("midrst_ready", 32'(pi.in_ready), 1);
    @(posedge clk); #1;

    // repeated identical plots
    w0 = wr_count;
`ifdef FB_PIXEL_SINK_DEDUP_EN
    send(1, 110, 3'b100, 1);
    for (int i = 0; i < 3; i++)
      send(1, 110, 3'b100, 0);
    repeat (6) @(negedge clk);
    check("dedup_writes", wr_count - w0, 1);
`else
    for (int i = 0; i < 4; i++)
      send(1, 110, 3'b100, 1);
    repeat (6) @(negedge clk);
    check("repeat_writes", wr_count - w0, 4);
`endif

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
